forwarding_scoreboard: RTL and testbench

//  Parametrised N-lane operand forwarding unit for the superscalar pipeline.

---
 rtl/forwarding_scoreboard.sv | 118 +++++++++++
 tb/tb_forwarding_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// N-lane operand forwarding unit: tracks in-flight destinations in a shift pipeline and
// produces age-prioritised forward selects, a load-use stall and a saturating stall counter.
module forwarding_scoreboard #(
    parameter int LANES   = 2,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 2,
    parameter int FWD_W   = $clog2(LANES*DEPTH+1),
    parameter int CNT_W   = 16,
    parameter int FIRST_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [LANES-1:0]        iss_valid,
    input  logic [LANES-1:0]        iss_reg_write,
    input  logic [LANES-1:0]        iss_mem_read,
    input  logic [LANES*REG_AW-1:0] iss_rd,
    input  logic [FIRST_W-1:0]      iss_first,
    input  logic [LANES*REG_AW-1:0] ex_rs,
    input  logic [LANES*REG_AW-1:0] ex_rt,
    output logic [LANES*FWD_W-1:0]  fwd_a,
    output logic [LANES*FWD_W-1:0]  fwd_b,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_count
);

    logic [DEPTH-1:0][LANES-1:0]             v_q, v_d;
    logic [DEPTH-1:0][LANES-1:0]             w_q, w_d;
    logic [DEPTH-1:0][LANES-1:0]             m_q, m_d;
    logic [DEPTH-1:0][LANES-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][FIRST_W-1:0]           first_q, first_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;

    logic              stall_c;
    logic [REG_AW-1:0] src;
    logic [FWD_W-1:0]  sel;
    logic              ld;

    // Lane at age position p (0 = oldest) of a group whose oldest lane is f.
    function automatic int lane_of(input logic [FIRST_W-1:0] f, input int p);
        return (int'(f) + p) % LANES;
    endfunction

    // Scan oldest stage/lane to youngest so the last hit is the highest-priority producer.
    always_comb begin
        fwd_a   = '0;
        fwd_b   = '0;
        stall_c = 1'b0;
        src     = '0;
        sel     = '0;
        ld      = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int op = 0; op < 2; op++) begin
                src = (op == 0) ? ex_rs[l*REG_AW +: REG_AW] : ex_rt[l*REG_AW +: REG_AW];
                sel = '0;
                ld  = 1'b0;
                for (int k = DEPTH-1; k >= 0; k--) begin
                    for (int p = 0; p < LANES; p++) begin
                        if (src != '0 && v_q[k][lane_of(first_q[k], p)]
                            && w_q[k][lane_of(first_q[k], p)]
                            && rd_q[k][lane_of(first_q[k], p)] == src) begin
                            sel = FWD_W'(1 + k*LANES + lane_of(first_q[k], p));
                            ld  = (k == 0) && m_q[k][lane_of(first_q[k], p)];
                        end
                    end
                end
                if (op == 0) fwd_a[l*FWD_W +: FWD_W] = sel;
                else         fwd_b[l*FWD_W +: FWD_W] = sel;
                stall_c = stall_c | ld;
            end
        end
    end

    always_comb begin
        v_d     = v_q;
        w_d     = w_q;
        m_d     = m_q;
        rd_d    = rd_q;
        first_d = first_q;
        for (int k = 1; k < DEPTH; k++) begin
            v_d[k]     = v_q[k-1];
            w_d[k]     = w_q[k-1];
            m_d[k]     = m_q[k-1];
            rd_d[k]    = rd_q[k-1];
            first_d[k] = first_q[k-1];
        end
        // A stalled or flushed group enters EX/MEM as a bubble.
        v_d[0]     = (stall_c || flush) ? '0 : iss_valid;
        w_d[0]     = iss_reg_write;
        m_d[0]     = iss_mem_read;
        first_d[0] = iss_first;
        for (int l = 0; l < LANES; l++)
            rd_d[0][l] = iss_rd[l*REG_AW +: REG_AW];
        cnt_d = (stall_c && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q     <= '0;
            w_q     <= '0;
            m_q     <= '0;
            rd_q    <= '0;
            first_q <= '0;
            cnt_q   <= '0;
        end else begin
            v_q     <= v_d;
            w_q     <= w_d;
            m_q     <= m_d;
            rd_q    <= rd_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall       = stall_c;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: directed steps then random traffic against an age-ordered history model.
module tb_forwarding_scoreboard;
    localparam int L  = 2;
    localparam int AW = 5;
    localparam int D  = 2;
    localparam int FW = $clog2(L*D+1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic [L-1:0]    iss_valid = '0, iss_reg_write = '0, iss_mem_read = '0;
    logic [L*AW-1:0] iss_rd = '0, ex_rs = '0, ex_rt = '0;
    logic [0:0]      iss_first = '0;
    logic [L*FW-1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic            stall, stall2;
    logic [15:0]     cnt16;
    logic [1:0]      cnt2;

    int checks = 0;
    int failures = 0;

    // History model: h*[k] is the group that entered EX/MEM k cycles ago.
    bit h_v[D][L], h_w[D][L], h_m[D][L];
    int h_rd[D][L];
    int h_first[D];
    int m_cnt = 0;

    forwarding_scoreboard #(.LANES(L), .REG_AW(AW), .DEPTH(D), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .iss_valid(iss_valid),
        .iss_reg_write(iss_reg_write), .iss_mem_read(iss_mem_read), .iss_rd(iss_rd),
        .iss_first(iss_first), .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .stall_count(cnt16));

    forwarding_scoreboard #(.LANES(L), .REG_AW(AW), .DEPTH(D), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .iss_valid(iss_valid),
        .iss_reg_write(iss_reg_write), .iss_mem_read(iss_mem_read), .iss_rd(iss_rd),
        .iss_first(iss_first), .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .stall(stall2), .stall_count(cnt2));

    always #5 clk = ~clk;

    // Youngest-first search: stage 0 before 1, youngest lane of a group first.
    function automatic int msel(input int src, output bit is_ld);
        is_ld = 1'b0;
        if (src == 0) return 0;
        for (int k = 0; k < D; k++)
            for (int p = L-1; p >= 0; p--) begin
                int ln;
                ln = (h_first[k] + p) % L;
                if (h_v[k][ln] && h_w[k][ln] && h_rd[k][ln] == src) begin
                    is_ld = (k == 0) && h_m[k][ln];
                    return 1 + k*L + ln;
                end
            end
        return 0;
    endfunction

    function automatic bit mstall();
        bit any, ld;
        int s;
        any = 1'b0;
        for (int l = 0; l < L; l++) begin
            s = msel(int'(ex_rs[l*AW +: AW]), ld); any |= ld;
            s = msel(int'(ex_rt[l*AW +: AW]), ld); any |= ld;
        end
        return any;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit s;
        s = mstall();
        @(posedge clk);
        if (!reset_n) begin
            for (int k = 0; k < D; k++) for (int l = 0; l < L; l++) h_v[k][l] = 1'b0;
            m_cnt = 0;
        end else begin
            for (int k = D-1; k >= 1; k--) begin
                h_first[k] = h_first[k-1];
                for (int l = 0; l < L; l++) begin
                    h_v[k][l] = h_v[k-1][l]; h_w[k][l] = h_w[k-1][l];
                    h_m[k][l] = h_m[k-1][l]; h_rd[k][l] = h_rd[k-1][l];
                end
            end
            h_first[0] = int'(iss_first);
            for (int l = 0; l < L; l++) begin
                h_v[0][l]  = iss_valid[l] && !s && !flush;
                h_w[0][l]  = iss_reg_write[l];
                h_m[0][l]  = iss_mem_read[l];
                h_rd[0][l] = int'(iss_rd[l*AW +: AW]);
            end
            if (s) m_cnt++;
        end
        #1;
    endtask

    task automatic check_all();
        bit ld;
        #1;
        for (int l = 0; l < L; l++) begin
            chk("fwd_a", fwd_a[l*FW +: FW], msel(int'(ex_rs[l*AW +: AW]), ld));
            chk("fwd_b", fwd_b[l*FW +: FW], msel(int'(ex_rt[l*AW +: AW]), ld));
        end
        chk("stall", stall, mstall());
        chk("stall_cnt2", stall2, mstall());
        chk("count16", cnt16, m_cnt > 65535 ? 65535 : m_cnt);
        chk("count2", cnt2, m_cnt > 3 ? 3 : m_cnt);
    endtask

    task automatic set_iss(input logic [1:0] v, input logic [1:0] w, input logic [1:0] m,
                           input int rd0, input int rd1, input int first);
        iss_valid = v; iss_reg_write = w; iss_mem_read = m;
        iss_rd = {AW'(rd1), AW'(rd0)}; iss_first = 1'(first);
    endtask

    task automatic set_ex(input int rs0, input int rs1, input int rt0, input int rt1);
        ex_rs = {AW'(rs1), AW'(rs0)}; ex_rt = {AW'(rt1), AW'(rt0)};
    endtask

    initial begin
        // Reset with garbage on every input.
        reset_n = 1'b0; flush = 1'b1;
        set_iss(2'b11, 2'b11, 2'b11, 7, 9, 1); set_ex(7, 9, 9, 7);
        tick();
        check_all();
        chk("reset_fwd_a", fwd_a, 0); chk("reset_stall", stall, 0); chk("reset_cnt", cnt16, 0);
        reset_n = 1'b1; flush = 1'b0;
        set_iss(0, 0, 0, 0, 0, 0); set_ex(0, 0, 0, 0);
        tick(); check_all();

        // Basic forward through stage 0 then stage 1.
        set_iss(2'b01, 2'b01, 0, 5, 0, 0);
        tick();
        set_iss(0, 0, 0, 0, 0, 0); set_ex(5, 0, 0, 0);
        check_all(); chk("t2_s0", fwd_a[FW-1:0], 1);
        tick(); check_all(); chk("t2_s1", fwd_a[FW-1:0], 3);
        tick(); check_all(); chk("t2_gone", fwd_a[FW-1:0], 0);

        // Within-group age order via first.
        set_iss(2'b11, 2'b11, 0, 7, 7, 0); set_ex(0, 0, 0, 0);
        tick();
        set_ex(0, 0, 7, 0);
        check_all(); chk("t3_first0", fwd_b[FW-1:0], 2);
        set_iss(2'b11, 2'b11, 0, 7, 7, 1);
        tick(); check_all(); chk("t3_first1", fwd_b[FW-1:0], 1);
        set_iss(0, 0, 0, 0, 0, 0); set_ex(0, 0, 0, 0);
        tick(); tick();

        // Load-use stall, then forward from stage 1.
        set_iss(2'b01, 2'b01, 2'b01, 9, 0, 0);
        tick();
        set_iss(0, 0, 0, 0, 0, 0); set_ex(9, 0, 0, 0);
        check_all(); chk("t4_stall", stall, 1);
        tick(); check_all();
        chk("t4_nostall", stall, 0); chk("t4_s1", fwd_a[FW-1:0], 3); chk("t4_cnt", cnt16, 1);

        // r0 never forwarded; flushed group never forwarded.
        set_iss(2'b01, 2'b01, 0, 0, 0, 0); set_ex(0, 0, 0, 0);
        tick(); check_all(); chk("t5_r0", fwd_a[FW-1:0], 0);
        set_iss(2'b01, 2'b01, 0, 4, 0, 0); flush = 1'b1;
        tick();
        flush = 1'b0; set_iss(0, 0, 0, 0, 0, 0); set_ex(4, 0, 0, 0);
        check_all(); chk("t5_flush", fwd_a[FW-1:0], 0);

        // Younger non-load shadows older load in the same stage; reversed age stalls.
        set_iss(2'b11, 2'b11, 2'b01, 6, 6, 0); set_ex(0, 0, 0, 0);
        tick(); set_ex(0, 0, 6, 0);
        check_all(); chk("shadow_sel", fwd_b[FW-1:0], 2); chk("shadow_nostall", stall, 0);
        set_iss(2'b11, 2'b11, 2'b01, 6, 6, 1); set_ex(0, 0, 0, 0);
        tick(); set_ex(0, 0, 6, 0); set_iss(0, 0, 0, 0, 0, 0);
        check_all(); chk("young_load_stall", stall, 1);
        tick(); check_all();

        // Counter saturation: repeated load-use events.
        for (int i = 0; i < 5; i++) begin
            set_iss(2'b10, 2'b10, 2'b10, 0, 11, 0); set_ex(0, 0, 0, 0);
            tick();
            set_iss(0, 0, 0, 0, 0, 0); set_ex(0, 11, 0, 0);
            check_all(); chk("sat_stall", stall, 1);
            tick(); check_all();
        end
        chk("sat_cnt2", cnt2, 3);
        set_iss(2'b01, 2'b01, 2'b01, 12, 0, 0); set_ex(0, 0, 0, 0);
        tick(); set_iss(0, 0, 0, 0, 0, 0); set_ex(12, 0, 0, 0);
        check_all(); reset_n = 1'b0;
        tick(); reset_n = 1'b1;
        check_all(); chk("midstall_reset_cnt", cnt16, 0); chk("midstall_reset_cnt2", cnt2, 0);

        // Random traffic over a small register range to provoke overlaps.
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            flush = ($urandom_range(0, 7) == 0);
            set_iss(2'($urandom), 2'($urandom), 2'($urandom),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
            set_ex(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            check_all();
            tick();
        end
        reset_n = 1'b1; flush = 1'b0;
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
